// File: rtl/board_engine_nxn_pkg.sv
// Shared definitions for the NxN 2048 board engine: direction codes, FSM
// states, spawn LFSR constants and board indexing helpers.
package board_2048_pkg;

  localparam logic [1:0] DIR_LEFT  = 2'b00;
  localparam logic [1:0] DIR_RIGHT = 2'b01;
  localparam logic [1:0] DIR_UP    = 2'b10;
  localparam logic [1:0] DIR_DOWN  = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    SPAWN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // x^16 + x^14 + x^13 + x^11 + 1, shifting left: feedback from bits 15,13,12,10.
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // Bit offset of tile (r,c) inside a row-major packed board image.
  function automatic int tile_offset(input int r, input int c, input int n, input int tw);
    return (r * n + c) * tw;
  endfunction

  // Cell index of position pos (0 = head) along line number line for a move direction.
  function automatic int cell_index(input logic [1:0] dir, input int line, input int pos,
                                    input int n);
    case (dir)
      DIR_LEFT:  return line * n + pos;
      DIR_RIGHT: return line * n + (n - 1 - pos);
      DIR_UP:    return pos * n + line;
      default:   return (n - 1 - pos) * n + line;
    endcase
  endfunction

endpackage

// File: rtl/board_engine_nxn_if.sv
// Request/status bundle between the button front-end, the board engine and
// the renderer.
//
// Handshake: the engine accepts a request on a rising clk edge where ready=1.
// load_req has priority over move_req in the same cycle. Requests presented
// while ready=0 are dropped, never queued. Each accepted move ends with a
// single-cycle done pulse, and moved/won/game_over/score_delta/board_out are
// already valid in that cycle. state mirrors the engine FSM for observation.
interface board_engine_nxn_if #(
  parameter int N  = 4,
  parameter int TW = 4,
  parameter int SW = 20
);
  import board_2048_pkg::*;

  logic                  load_req;
  logic [0:N*N*TW-1]     load_board;
  logic                  move_req;
  logic [1:0]            move_dir;
  logic                  ready;
  logic                  done;
  logic                  moved;
  logic                  won;
  logic                  game_over;
  logic [SW-1:0]         score_delta;
  logic [0:N*N*TW-1]     board_out;
  state_t                state;

  modport master (
    output load_req, load_board, move_req, move_dir,
    input  ready, done, moved, won, game_over, score_delta, board_out, state
  );

  modport slave (
    input  load_req, load_board, move_req, move_dir,
    output ready, done, moved, won, game_over, score_delta, board_out, state
  );

endinterface

// File: rtl/board_engine_nxn_line_merge.sv
// Combinational 2048 slide/merge of one line, tiles ordered head-first.
// Reports the merge score (saturating), whether the line changed and whether
// any merge reached WIN_EXP.
module line_merge_2048 #(
  parameter int N       = 4,
  parameter int TW      = 4,
  parameter int SW      = 20,
  parameter int WIN_EXP = 11
) (
  input  logic [N*TW-1:0] tiles_in,
  output logic [N*TW-1:0] tiles_out,
  output logic [SW-1:0]   line_score,
  output logic            changed,
  output logic            win_hit
);

  localparam logic [TW-1:0] TILE_MAX = '1;

  logic [TW-1:0] packed_t [N+1];
  logic [TW-1:0] merged   [N];
  logic [SW:0]   acc;
  logic [SW-1:0] inc;
  logic          skip;
  int            cnt;
  int            fill;

  // Compress toward the head, merge equal pairs once each, then repack.
  always_comb begin
    for (int i = 0; i <= N; i++) packed_t[i] = '0;
    for (int i = 0; i < N; i++) merged[i] = '0;
    line_score = '0;
    win_hit    = 1'b0;
    skip       = 1'b0;
    acc        = '0;
    inc        = '0;
    cnt        = 0;
    fill       = 0;
    tiles_out  = '0;

    for (int i = 0; i < N; i++) begin
      if (tiles_in[i*TW +: TW] != '0) begin
        packed_t[cnt] = tiles_in[i*TW +: TW];
        cnt = cnt + 1;
      end
    end

    // packed_t[N] is always zero, so the last tile never finds a partner.
    for (int i = 0; i < N; i++) begin
      if (skip) begin
        skip = 1'b0;
      end else if (packed_t[i] != '0) begin
        if (packed_t[i+1] == packed_t[i] && packed_t[i] != TILE_MAX) begin
          merged[fill] = packed_t[i] + 1'b1;
          if (int'(packed_t[i]) + 1 >= SW) inc = '1;
          else inc = SW'(1) << (int'(packed_t[i]) + 1);
          acc = {1'b0, line_score} + {1'b0, inc};
          line_score = acc[SW] ? '1 : acc[SW-1:0];
          if (int'(packed_t[i]) + 1 >= WIN_EXP) win_hit = 1'b1;
          skip = 1'b1;
        end else begin
          merged[fill] = packed_t[i];
        end
        fill = fill + 1;
      end
    end

    for (int i = 0; i < N; i++) tiles_out[i*TW +: TW] = merged[i];
    changed = (tiles_out != tiles_in);
  end

endmodule

// File: rtl/board_engine_nxn.sv
// NxN 2048 board engine: holds the committed board, performs load and move
// requests one line per clock through a single shared line_merge_2048, and
// publishes moved/won/game_over/score status.
// Optional tile spawn after a changing move: define BOARD_SPAWN_EN.
module board_engine_nxn
  import board_2048_pkg::*;
#(
  parameter int N       = 4,
  parameter int TW      = 4,
  parameter int SW      = 20,
  parameter int WIN_EXP = 11
) (
  input logic              clk,
  input logic              clr,
  board_engine_nxn_if.slave bus
);

  localparam int CELLS = N * N;
  localparam int LW    = (N > 1) ? $clog2(N) : 1;

  typedef logic [TW-1:0] board_t [CELLS];

  state_t            state_q, state_d;
  board_t            board_q, work_q, load_tiles;
  logic [1:0]        dir_q;
  logic [LW-1:0]     line_q;
  logic [SW-1:0]     score_acc_q, score_delta_q, score_sum;
  logic [SW:0]       score_wide;
  logic              changed_q, won_acc_q, moved_q, won_q, over_q, done_q;
  logic              ready_int, last_line;
  logic [N*TW-1:0]   line_in, line_out;
  logic [SW-1:0]     line_score;
  logic              line_changed, line_win;
  logic [0:N*N*TW-1] board_flat;

  function automatic logic board_has_win(input board_t b);
    logic w;
    w = 1'b0;
    for (int i = 0; i < CELLS; i++) if (int'(b[i]) >= WIN_EXP) w = 1'b1;
    return w;
  endfunction

  // Stuck means no empty cell and no equal horizontal or vertical neighbours.
  function automatic logic board_stuck(input board_t b);
    logic s;
    s = 1'b1;
    for (int r = 0; r < N; r++) begin
      for (int c = 0; c < N; c++) begin
        if (b[r*N+c] == '0) s = 1'b0;
        if (c < N - 1 && b[r*N+c] == b[r*N+c+1]) s = 1'b0;
        if (r < N - 1 && b[r*N+c] == b[(r+1)*N+c]) s = 1'b0;
      end
    end
    return s;
  endfunction

  assign ready_int       = (state_q == IDLE) && !done_q;
  assign last_line       = (int'(line_q) == N - 1);
  assign score_wide      = {1'b0, score_acc_q} + {1'b0, line_score};
  assign score_sum       = score_wide[SW] ? '1 : score_wide[SW-1:0];

  assign bus.ready       = ready_int;
  assign bus.done        = done_q;
  assign bus.moved       = moved_q;
  assign bus.won         = won_q;
  assign bus.game_over   = over_q;
  assign bus.score_delta = score_delta_q;
  assign bus.board_out   = board_flat;
  assign bus.state       = state_q;

  // Unpack the load image and pack the committed board, both row-major.
  always_comb begin
    board_flat = '0;
    for (int r = 0; r < N; r++) begin
      for (int c = 0; c < N; c++) begin
        load_tiles[r*N+c] = bus.load_board[tile_offset(r, c, N, TW) +: TW];
        board_flat[tile_offset(r, c, N, TW) +: TW] = board_q[r*N+c];
      end
    end
  end

  // Gather the current line head-first from the working board.
  always_comb begin
    line_in = '0;
    for (int i = 0; i < N; i++)
      line_in[i*TW +: TW] = work_q[cell_index(dir_q, int'(line_q), i, N)];
  end

  line_merge_2048 #(.N(N), .TW(TW), .SW(SW), .WIN_EXP(WIN_EXP)) u_merge (
    .tiles_in   (line_in),
    .tiles_out  (line_out),
    .line_score (line_score),
    .changed    (line_changed),
    .win_hit    (line_win)
  );

`ifdef BOARD_SPAWN_EN
  logic [15:0]   lfsr_q;
  logic          spawn_found;
  int            spawn_idx;
  logic [TW-1:0] spawn_val;

  // Free-running spawn LFSR.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) lfsr_q <= LFSR_SEED;
    else     lfsr_q <= {lfsr_q[14:0], ^(lfsr_q & LFSR_TAPS)};
  end

  // First empty cell from a pseudo-random start, scanning upward with wrap.
  always_comb begin
    spawn_found = 1'b0;
    spawn_idx   = 0;
    spawn_val   = (lfsr_q[15:13] == 3'b111) ? TW'(2) : TW'(1);
    for (int k = 0; k < CELLS; k++) begin
      if (!spawn_found && work_q[(int'(lfsr_q[7:0]) % CELLS + k) % CELLS] == '0) begin
        spawn_found = 1'b1;
        spawn_idx   = (int'(lfsr_q[7:0]) % CELLS + k) % CELLS;
      end
    end
  end
`endif

  // FSM state register.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // FSM next-state: accept, walk N lines, optionally spawn, then commit.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (ready_int && !bus.load_req && bus.move_req) state_d = SHIFT;
      SHIFT: begin
        if (last_line) begin
`ifdef BOARD_SPAWN_EN
          state_d = (changed_q || line_changed) ? SPAWN : DONE;
`else
          state_d = DONE;
`endif
        end
      end
      SPAWN: state_d = DONE;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Board datapath and status registers.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      for (int i = 0; i < CELLS; i++) begin
        board_q[i] <= '0;
        work_q[i]  <= '0;
      end
      dir_q         <= DIR_LEFT;
      line_q        <= '0;
      score_acc_q   <= '0;
      score_delta_q <= '0;
      changed_q     <= 1'b0;
      won_acc_q     <= 1'b0;
      moved_q       <= 1'b0;
      won_q         <= 1'b0;
      over_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (ready_int && bus.load_req) begin
            board_q       <= load_tiles;
            moved_q       <= 1'b0;
            score_delta_q <= '0;
            won_q         <= board_has_win(load_tiles);
            over_q        <= board_stuck(load_tiles);
          end else if (ready_int && bus.move_req) begin
            dir_q       <= bus.move_dir;
            work_q      <= board_q;
            line_q      <= '0;
            score_acc_q <= '0;
            changed_q   <= 1'b0;
            won_acc_q   <= 1'b0;
          end
        end
        SHIFT: begin
          for (int i = 0; i < N; i++)
            work_q[cell_index(dir_q, int'(line_q), i, N)] <= line_out[i*TW +: TW];
          line_q      <= line_q + 1'b1;
          score_acc_q <= score_sum;
          changed_q   <= changed_q | line_changed;
          won_acc_q   <= won_acc_q | line_win;
        end
        SPAWN: begin
`ifdef BOARD_SPAWN_EN
          if (spawn_found) work_q[spawn_idx] <= spawn_val;
`endif
        end
        DONE: begin
          board_q       <= work_q;
          moved_q       <= changed_q;
          score_delta_q <= score_acc_q;
          won_q         <= won_q | won_acc_q;
          over_q        <= board_stuck(work_q);
          done_q        <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_board_engine_nxn.sv
// Directed bench for board_engine_nxn, N=4, TW=4, spawn disabled.
// Boards are written as 64-bit hex, one nibble per tile, row-major from the
// top-left tile.
module tb_board_engine_nxn;
  import board_2048_pkg::*;

  localparam int N  = 4;
  localparam int TW = 4;
  localparam int SW = 20;

  logic clk;
  logic clr;
  int   tests_run;
  int   tests_failed;
  int   lat;
  int   dones;
  logic [63:0] exp_q[$];
  logic [63:0] exp_board;

  board_engine_nxn_if #(.N(N), .TW(TW), .SW(SW)) bus ();

  board_engine_nxn #(.N(N), .TW(TW), .SW(SW), .WIN_EXP(11)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  // Clock and reset.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    @(negedge clk);
    while (!bus.ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("ready_before_request", bus.ready, 1'b1);
  endtask

  task automatic do_load(input logic [63:0] b);
    wait_ready();
    bus.load_req   = 1'b1;
    bus.load_board = b;
    @(posedge clk);
    #1;
    bus.load_req = 1'b0;
  endtask

  // Issue a move and return the number of edges from acceptance to done
  // (-1 if done never came). poke_busy presents a second move while busy.
  task automatic do_move(input logic [1:0] d, input bit poke_busy, output int latency);
    wait_ready();
    bus.move_req = 1'b1;
    bus.move_dir = d;
    @(posedge clk);
    #1;
    bus.move_req = 1'b0;
    latency = -1;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk);
      #1;
      if (poke_busy && c == 1) begin
        bus.move_req = 1'b1;
        bus.move_dir = DIR_RIGHT;
      end
      if (c == 2) bus.move_req = 1'b0;
      if (bus.done) begin
        latency = c;
        break;
      end
    end
  endtask

  task automatic count_dones(input int cycles, output int n);
    n = 0;
    for (int c = 0; c < cycles; c++) begin
      @(posedge clk);
      #1;
      if (bus.done) n++;
    end
  endtask

  task automatic check_board(input string tag);
    exp_board = exp_q.pop_front();
    check(tag, bus.board_out, exp_board);
  endtask

  initial begin
    tests_run      = 0;
    tests_failed   = 0;
    clr            = 1'b1;
    bus.load_req   = 1'b0;
    bus.load_board = '0;
    bus.move_req   = 1'b0;
    bus.move_dir   = DIR_LEFT;
    repeat (2) @(negedge clk);
    clr = 1'b0;

    // Reset state.
    check("rst_board", bus.board_out, 64'h0);
    check("rst_ready", bus.ready, 1'b1);
    check("rst_done", bus.done, 1'b0);
    check("rst_moved", bus.moved, 1'b0);
    check("rst_won", bus.won, 1'b0);
    check("rst_over", bus.game_over, 1'b0);
    check("rst_score", bus.score_delta, 20'd0);
    check("rst_state", bus.state, IDLE);

    // Pairwise merge left with latency check.
    do_load(64'h1122_0000_0000_0000);
    check("load_board", bus.board_out, 64'h1122_0000_0000_0000);
    exp_q.push_back(64'h2300_0000_0000_0000);
    do_move(DIR_LEFT, 1'b0, lat);
    check("left_latency", lat, 5);
    check_board("left_board");
    check("left_score", bus.score_delta, 20'd12);
    check("left_moved", bus.moved, 1'b1);
    check("left_ready_in_done", bus.ready, 1'b0);

    // Four equal tiles right: two merges, no chaining.
    do_load(64'h1111_0000_0000_0000);
    exp_q.push_back(64'h0022_0000_0000_0000);
    do_move(DIR_RIGHT, 1'b0, lat);
    check("right_latency", lat, 5);
    check_board("right_board");
    check("right_score", bus.score_delta, 20'd8);

    // Column up: the third 3 must not merge again.
    do_load(64'h3000_0000_3000_3000);
    exp_q.push_back(64'h4000_3000_0000_0000);
    do_move(DIR_UP, 1'b0, lat);
    check_board("up_board");
    check("up_score", bus.score_delta, 20'd16);
    check("up_moved", bus.moved, 1'b1);

    // No legal left move: board unchanged but done still pulses.
    do_load(64'h1234_5600_7000_0000);
    exp_q.push_back(64'h1234_5600_7000_0000);
    do_move(DIR_LEFT, 1'b0, lat);
    check("nomove_latency", lat, 5);
    check_board("nomove_board");
    check("nomove_moved", bus.moved, 1'b0);
    check("nomove_score", bus.score_delta, 20'd0);

    // Down move on a column pair.
    do_load(64'h0000_0500_0000_0500);
    exp_q.push_back(64'h0000_0000_0000_0600);
    do_move(DIR_DOWN, 1'b0, lat);
    check_board("down_board");
    check("down_score", bus.score_delta, 20'd64);

    // Reaching 2048 sets won, and it stays set across a later move.
    do_load(64'hAA00_0000_0000_0000);
    check("win_pre_load", bus.won, 1'b0);
    exp_q.push_back(64'hB000_0000_0000_0000);
    do_move(DIR_LEFT, 1'b0, lat);
    check_board("win_board");
    check("win_flag", bus.won, 1'b1);
    check("win_score", bus.score_delta, 20'd2048);
    exp_q.push_back(64'h000B_0000_0000_0000);
    do_move(DIR_RIGHT, 1'b0, lat);
    check_board("win_sticky_board");
    check("win_sticky", bus.won, 1'b1);

    // Saturated exponent never merges.
    do_load(64'hFF00_0000_0000_0000);
    check("sat_load_won", bus.won, 1'b1);
    exp_q.push_back(64'hFF00_0000_0000_0000);
    do_move(DIR_LEFT, 1'b0, lat);
    check_board("sat_board");
    check("sat_moved", bus.moved, 1'b0);
    check("sat_score", bus.score_delta, 20'd0);

    // Game-over detection on load.
    do_load(64'h1212_2121_1212_2121);
    check("over_checker", bus.game_over, 1'b1);
    check("over_checker_won", bus.won, 1'b0);
    do_load(64'h1212_2121_1212_2122);
    check("over_pair_left", bus.game_over, 1'b0);

    // A request while busy is dropped, not queued.
    do_load(64'h1100_0000_0000_0000);
    exp_q.push_back(64'h2000_0000_0000_0000);
    do_move(DIR_LEFT, 1'b1, lat);
    check("busy_latency", lat, 5);
    check_board("busy_board");
    count_dones(10, dones);
    check("busy_no_second_done", dones, 0);
    check("busy_board_after", bus.board_out, 64'h2000_0000_0000_0000);

    // Asynchronous clear in the middle of SHIFT (line 2).
    do_load(64'h1122_0000_0000_0000);
    wait_ready();
    bus.move_req = 1'b1;
    bus.move_dir = DIR_LEFT;
    @(posedge clk);
    #1;
    bus.move_req = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    check("clr_in_shift", bus.state, SHIFT);
    clr = 1'b1;
    #1;
    check("clr_board", bus.board_out, 64'h0);
    check("clr_ready", bus.ready, 1'b1);
    check("clr_state", bus.state, IDLE);
    check("clr_done", bus.done, 1'b0);
    @(negedge clk);
    clr = 1'b0;
    count_dones(8, dones);
    check("clr_no_done", dones, 0);

    // Load and move together: load wins and no move runs.
    wait_ready();
    bus.load_req   = 1'b1;
    bus.load_board = 64'h1100_0000_0000_0000;
    bus.move_req   = 1'b1;
    bus.move_dir   = DIR_LEFT;
    @(posedge clk);
    #1;
    bus.load_req = 1'b0;
    bus.move_req = 1'b0;
    check("both_state", bus.state, IDLE);
    count_dones(8, dones);
    check("both_no_done", dones, 0);
    check("both_board", bus.board_out, 64'h1100_0000_0000_0000);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/board_engine_nxn.md
Name: board_engine_nxn

Overview:
- Parametrised successor to the fixed 4x4 2048 game controller.
- Holds an NxN board of tile exponents and accepts load and move requests through a ready/done handshake.
- Slides and merges one line per clock, then reports moved/won/game-over/score status.
- Sits between the button front-end and the VGA board renderer; board_out drives the renderer directly.

Parameters:
- N, 4, board edge length (2..8).
- TW, 4, tile exponent width. 0 = empty, k = tile 2^k.
- SW, 20, score_delta width (saturating).
- WIN_EXP, 11, exponent that asserts won (11 = tile 2048).

Ports:
- clk  in  1  system clock.
- clr  in  1  reset.
- load_req  in  1  load load_board into the board.
- load_board  in  N*N*TW  board image, same packing as board_out.
- move_req  in  1  move request, sampled only when ready=1.
- move_dir  in  2  00 left, 01 right, 10 up, 11 down.
- ready  out  1  engine idle; accepts requests.
- done  out  1  one-cycle pulse when a move completes.
- moved  out  1  last move changed the board.
- won  out  1  sticky flag: a merge produced exponent >= WIN_EXP.
- game_over  out  1  no empty cell and no equal orthogonal neighbours.
- score_delta  out  SW  sum of 2^e over all merges of the last move.
- board_out  out  N*N*TW  committed board. Declared [0:N*N*TW-1]; tile (r,c) occupies bits [(r*N+c)*TW +: TW], row-major, index 0 = top-left.

Behaviour:
- Reset: clk is the single clock; clr is asynchronous, active-high.
  - board_out=0, ready=1, done=0, moved=0, won=0, game_over=0, score_delta=0, state=IDLE.
  - clr during any state aborts the operation immediately. No done pulse; the partially processed board is discarded.
- IDLE:
  - load_req=1: board_out<=load_board next edge; won and game_over recomputed from the loaded image; moved=0, score_delta=0.
  - load_req and move_req in the same cycle: load wins; the move is dropped.
  - move_req=1 (no load): latch move_dir, copy board into the working register, line counter L=0, clear per-move score. Go to SHIFT; ready=0.
- SHIFT, one line per cycle, L=0..N-1:
  - left/right act on row L; up/down act on column L.
  - Head is col 0 (left), col N-1 (right), row 0 (up), row N-1 (down).
  - Merge rule:
    - Compress non-zero tiles toward the head.
    - Scan from the head; two equal adjacent non-zero tiles e merge into e+1, at most once per tile.
    - Tiles with e = 2^TW-1 never merge (saturation).
    - Each merge adds 2^(e+1) to the score; the accumulator saturates at 2^SW-1.
  - After L=N-1, go to SPAWN if the feature is compiled and the working board differs from board_out; otherwise go to DONE.
- DONE, 1 cycle:
  - Commit the working board to board_out.
  - Update moved, score_delta, won (OR-accumulated) and game_over.
  - done=1 for exactly this cycle; ready=1 from the next cycle.
  - Latency from move_req acceptance edge to done: N+1 cycles, or N+2 when a spawn occurs.
- move_req or load_req while ready=0: ignored, not queued.
- A move that changes nothing gives moved=0, score_delta=0, board unchanged, and still pulses done.

Optional Feature:
- Macro: BOARD_SPAWN_EN.
- Defined:
  - Free-running 16-bit LFSR, taps x^16+x^14+x^13+x^11+1, reset seed 16'hACE1.
  - SPAWN state (1 cycle):
    - start = lfsr[7:0] mod N*N.
    - Scan ascending with wrap for the first empty cell.
    - Write exponent 2 if lfsr[15:13]=3'b111, else 1.
  - No empty cell means no write.
  - SPAWN is entered only when the move changed the board.
- Undefined: no LFSR and no SPAWN state; latency is always N+1.

Decomposition:
- Package board_2048_pkg holds:
  - dir codes DIR_LEFT/RIGHT/UP/DOWN;
  - state enum {IDLE, SHIFT, SPAWN, DONE};
  - LFSR_SEED and LFSR_TAPS;
  - helper function for the tile bit offset.
- Sub-module line_merge_2048 (parameters N, TW, SW), purely combinational:
  - inputs: N tiles ordered head-first;
  - outputs: merged tiles, line score, changed flag, max-exponent-reached flag.
- The engine instantiates one line_merge_2048 and reuses it across the N SHIFT cycles.

Test Plan:
- N=4, TW=4, BOARD_SPAWN_EN off throughout.
- Load row0=[1,1,2,2] (other rows 0), move left.
  - Expect row0=[2,3,0,0], score_delta=12, moved=1.
  - Expect done exactly 5 cycles after acceptance.
- Row0=[1,1,1,1], move right.
  - Expect row0=[0,0,2,2], score_delta=8.
- Col0=[3,0,3,3] (top to bottom), move up.
  - Expect col0=[4,3,0,0]; the third 3 does not double-merge.
- Board with no legal left move, move left.
  - Expect moved=0, score_delta=0, board unchanged, done pulses.
- Row0=[10,10,0,0], move left.
  - Expect row0=[11,0,0,0] and won=1 (sticky).
- Row0=[15,15,0,0], move left.
  - Expect no merge and moved=0.
- Full checkerboard of 1/2 loaded.
  - Expect game_over=1 after load.
- Assert clr at SHIFT L=2.
  - Expect board_out=0 and ready=1 asynchronously, with no done pulse.
- Assert load_req and move_req together.
  - Expect the board to equal load_board and no done pulse.
